plot_receiver: RTL and testbench

- Receiving end of the plot/x/y pixel-write interface driven by the box-drawing FSM.
- Accepts one pixel per cycle when plot is high and buffers it in a small FIFO.
- Drains the FIFO into a 160x120, 3-bit-colour single-port frame-buffer RAM and supports a full-screen clear.
- Arbitrates the RAM port with the VGA scanout reader; scanout always wins.

---
 rtl/vga_pkg.sv | 34 +++
 rtl/pixel_fifo.sv | 62 ++++++
 rtl/plot_receiver.sv | 151 +++++++++++++++
 tb/tb_plot_receiver.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared definitions for the pixel-write path into the VGA frame buffer.
//   SCREEN_W / SCREEN_H : default frame dimensions in pixels
//   ADDR_W / COLOUR_W   : frame-buffer address and colour widths
//   rx_state_t          : plot_receiver FSM encoding
//   pixel_t             : one buffered pixel write {addr, colour}
//   pixel_addr()        : linear frame-buffer address of (x, y)
package vga_pkg;

  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;
  localparam int ADDR_W   = 15;
  localparam int COLOUR_W = 3;

  // IDLE covers both "nothing to do" and "draining the FIFO": the drain
  // decision uses the live FIFO empty flag, so no separate state is needed.
  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } rx_state_t;

  typedef struct packed {
    logic [ADDR_W-1:0]   addr;
    logic [COLOUR_W-1:0] colour;
  } pixel_t;

  // Row-major address; the row width is passed in so a top level built
  // for a different screen size still computes the right address.
  function automatic logic [ADDR_W-1:0] pixel_addr(input logic [7:0] x,
                                                   input logic [6:0] y,
                                                   input int         row_w);
    return ADDR_W'(y) * ADDR_W'(row_w) + ADDR_W'(x);
  endfunction

endpackage

// File: rtl/pixel_fifo.sv
// Small synchronous first-in first-out buffer.
//   clk, resetn : clock, synchronous active-low reset (empties the FIFO)
//   push        : write push_data (ignored when full)
//   pop         : discard the head entry (ignored when empty)
//   head        : oldest entry, valid whenever empty is low
//   full, empty : occupancy flags
//   count       : number of stored entries, 0..DEPTH
module pixel_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 18,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // DEPTH is a power of two, so the pointers wrap on their own.
  // NOTE: state registers use <= so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: ;
      endcase
    end
  end

  // NOTE: storage is deliberately not reset; an entry is only read after
  // it has been written, so a reset here would just cost flops and routing.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  assign head  = mem[rd_ptr];
  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/plot_receiver.sv
// Receiving end of the plot/x/y/colour pixel-write interface. Pixels are
// range-checked, buffered in a FIFO and drained into a single-port frame
// buffer RAM; a clear pulse fills the whole screen with CLEAR_COLOUR.
// The VGA scanout reader always wins the RAM port.
//   plot, x, y, colour : pixel write strobe and data
//   clear              : one-cycle pulse starting (or restarting) a clear
//   ready              : FIFO not full
//   busy               : FIFO non-empty or clear in progress
//   overflow           : sticky, an in-range pixel was lost to a full FIFO
//   oob_count          : saturating count of out-of-range pixels dropped
//   scan_req/scan_addr : scanout read request; scan_valid/scan_data one
//                        cycle later
//   mem_*              : frame-buffer RAM port (1-cycle synchronous read)
module plot_receiver #(
  parameter int         FIFO_DEPTH   = 4,
  parameter int         SCREEN_W     = vga_pkg::SCREEN_W,
  parameter int         SCREEN_H     = vga_pkg::SCREEN_H,
  parameter logic [2:0] CLEAR_COLOUR = 3'b000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        plot,
  input  logic [7:0]  x,
  input  logic [6:0]  y,
  input  logic [2:0]  colour,
  input  logic        clear,
  output logic        ready,
  output logic        busy,
  output logic        overflow,
  output logic [7:0]  oob_count,
  input  logic        scan_req,
  input  logic [14:0] scan_addr,
  output logic        scan_valid,
  output logic [2:0]  scan_data,
  output logic [14:0] mem_addr,
  output logic        mem_we,
  output logic [2:0]  mem_wdata,
  input  logic [2:0]  mem_rdata
);

  import vga_pkg::*;

  localparam int                PIXELS    = SCREEN_W * SCREEN_H;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(PIXELS - 1);
  localparam int                ENTRY_W   = $bits(pixel_t);
  localparam int                CNT_W     = $clog2(FIFO_DEPTH) + 1;

  rx_state_t         state;
  rx_state_t         state_next;
  logic [ADDR_W-1:0] clr_addr;
  logic              clr_grant;
  logic              in_range;
  logic              push;
  logic              pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [CNT_W-1:0]  fifo_count;
  pixel_t            push_entry;
  pixel_t            head_entry;

  // ---------------------------------------------------------------- enqueue
  assign in_range          = (int'(x) < SCREEN_W) && (int'(y) < SCREEN_H);
  assign push_entry.addr   = pixel_addr(x, y, SCREEN_W);
  assign push_entry.colour = colour;
  // Push is decided on the pre-pop count: a pop in the same cycle does
  // not make room for a pixel that arrives while the FIFO is full.
  assign push              = plot && in_range && !fifo_full;
  assign ready             = (fifo_count < CNT_W'(FIFO_DEPTH));

  pixel_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk       (clk),
    .resetn    (resetn),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .head      (head_entry),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (!resetn) begin
      overflow   <= 1'b0;
      oob_count  <= '0;
      scan_valid <= 1'b0;
    end else begin
      if (plot && in_range && fifo_full) overflow <= 1'b1;
      if (plot && !in_range && oob_count != 8'hFF) oob_count <= oob_count + 8'd1;
      scan_valid <= scan_req;
    end
  end

  // The RAM output register already holds the word addressed last cycle.
  assign scan_data = mem_rdata;

  // ---------------------------------------------------------- clear FSM
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state    <= ST_IDLE;
      clr_addr <= '0;
    end else begin
      state <= state_next;
      if (clear)          clr_addr <= '0;
      else if (clr_grant) clr_addr <= clr_addr + ADDR_W'(1);
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (clear) state_next = ST_CLEAR;
      end
      ST_CLEAR: begin
        // A restarting clear outranks completion of the current one.
        if (!clear && clr_grant && clr_addr == LAST_ADDR) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------- RAM port arbiter
  // NOTE: every output of this block gets a default first, so no path
  // through the if-chain can leave one unassigned and infer a latch.
  always_comb begin
    mem_addr  = scan_addr;
    mem_we    = 1'b0;
    mem_wdata = CLEAR_COLOUR;
    pop       = 1'b0;
    clr_grant = 1'b0;
    if (!scan_req) begin
      if (state == ST_CLEAR) begin
        mem_addr  = clr_addr;
        mem_we    = 1'b1;
        clr_grant = 1'b1;
      end else if (!fifo_empty) begin
        mem_addr  = head_entry.addr;
        mem_we    = 1'b1;
        mem_wdata = head_entry.colour;
        pop       = 1'b1;
      end
    end
  end

  assign busy = !fifo_empty || (state == ST_CLEAR);

endmodule

// File: tb/tb_plot_receiver.sv
// Scoreboard bench for plot_receiver. A behavioural model tracks pending
// pixel writes, the clear sweep and the expected frame contents; a monitor
// compares every RAM-port cycle and status output against that model.
module tb_plot_receiver;

  localparam int DEPTH = 4;
  localparam int W     = 160;
  localparam int H     = 120;
  localparam int NPIX  = W * H;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        plot = 1'b0;
  logic [7:0]  x = '0;
  logic [6:0]  y = '0;
  logic [2:0]  colour = '0;
  logic        clear = 1'b0;
  logic        scan_req = 1'b0;
  logic [14:0] scan_addr = '0;
  logic        ready, busy, overflow, scan_valid, mem_we;
  logic [7:0]  oob_count;
  logic [2:0]  scan_data, mem_wdata, mem_rdata;
  logic [14:0] mem_addr;

  always #5 clk = ~clk;

  plot_receiver #(.FIFO_DEPTH(DEPTH)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .plot      (plot),
    .x         (x),
    .y         (y),
    .colour    (colour),
    .clear     (clear),
    .ready     (ready),
    .busy      (busy),
    .overflow  (overflow),
    .oob_count (oob_count),
    .scan_req  (scan_req),
    .scan_addr (scan_addr),
    .scan_valid(scan_valid),
    .scan_data (scan_data),
    .mem_addr  (mem_addr),
    .mem_we    (mem_we),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  // Frame-buffer RAM: single port, registered read.
  bit   [2:0] ram [32768];
  logic [2:0] ram_q = '0;
  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    ram_q <= ram[mem_addr];
  end
  assign mem_rdata = ram_q;

  // ------------------------------------------------------------ model
  typedef struct { int addr; int col; } wr_t;
  wr_t pix_q[$];          // accepted pixels not yet written, in plot order
  bit  clr_active = 0;
  int  clr_next   = 0;
  bit  ovf_m      = 0;
  int  oob_m      = 0;
  bit  live       = 0;
  bit  popped     = 0;    // a pixel was written in the cycle just ending
  bit  scan_pend  = 0;
  int  scan_exp   = 0;
  int  exp_fb [NPIX];
  int  we_count   = 0;
  int  last_addr  = -1;
  int  last_pix_addr = -1;
  int  prev_of_last_pix = -1;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Apply the inputs sampled at each rising edge, then judge the DUT's
  // outputs for the following cycle at the falling edge.
  initial forever begin
    @(posedge clk);
    if (!resetn) begin
      pix_q.delete();
      clr_active = 0;
      clr_next   = 0;
      ovf_m      = 0;
      oob_m      = 0;
      scan_pend  = 0;
      live       = 1;
    end else if (live) begin
      if (plot) begin
        if (int'(x) >= W || int'(y) >= H) begin
          if (oob_m < 255) oob_m++;
        end else if (pix_q.size() + int'(popped) < DEPTH) begin
          pix_q.push_back('{addr: int'(y) * W + int'(x), col: int'(colour)});
        end else begin
          ovf_m = 1;
        end
      end
      if (clear) begin
        clr_active = 1;
        clr_next   = 0;
      end
    end
    popped = 0;

    @(negedge clk);
    if (live) begin
      wr_t w;
      check("ready", int'(ready), int'(pix_q.size() < DEPTH));
      check("busy", int'(busy), int'(pix_q.size() != 0 || clr_active));
      check("overflow", int'(overflow), int'(ovf_m));
      check("oob_count", int'(oob_count), oob_m);
      check("scan_valid", int'(scan_valid), int'(scan_pend));
      if (scan_pend) check("scan_data", int'(scan_data), scan_exp);
      scan_pend = scan_req;
      if (scan_req) scan_exp = (int'(scan_addr) < NPIX) ? exp_fb[scan_addr] : 0;
      if (mem_we) we_count++;
      if (scan_req) begin
        check("scan_we", int'(mem_we), 0);
        check("scan_mem_addr", int'(mem_addr), int'(scan_addr));
      end else if (clr_active) begin
        check("clr_we", int'(mem_we), 1);
        check("clr_addr", int'(mem_addr), clr_next);
        check("clr_data", int'(mem_wdata), 0);
        exp_fb[clr_next] = 0;
        last_addr = clr_next;
        clr_next++;
        if (clr_next == NPIX) clr_active = 0;
      end else if (pix_q.size() != 0) begin
        w = pix_q.pop_front();
        check("pix_we", int'(mem_we), 1);
        check("pix_addr", int'(mem_addr), w.addr);
        check("pix_data", int'(mem_wdata), w.col);
        exp_fb[w.addr]   = w.col;
        prev_of_last_pix = last_addr;
        last_pix_addr    = w.addr;
        last_addr        = w.addr;
        popped           = 1;
      end else begin
        check("idle_we", int'(mem_we), 0);
      end
    end
  end

  // ------------------------------------------------------------ stimulus
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n = 0;
    while ((pix_q.size() != 0 || clr_active) && n < budget) begin
      tick();
      n++;
    end
    check({name, "_drain_timeout"}, int'(pix_q.size() != 0 || clr_active), 0);
  endtask

  initial begin
    int base;
    int n;

    // Reset
    resetn = 0;
    tick();
    tick();
    check("rst_ready", int'(ready), 1);
    check("rst_busy", int'(busy), 0);
    check("rst_overflow", int'(overflow), 0);
    check("rst_oob", int'(oob_count), 0);
    check("rst_we", int'(mem_we), 0);
    check("rst_scan_valid", int'(scan_valid), 0);
    resetn = 1;

    // 1: single pixel, one-cycle latency
    plot = 1; x = 8'd4; y = 7'd10; colour = 3'b100;
    tick();
    plot = 0;
    check("t1_we", int'(mem_we), 1);
    check("t1_addr", int'(mem_addr), 1604);
    check("t1_data", int'(mem_wdata), 4);
    tick();
    check("t1_busy_low", int'(busy), 0);

    // 2: 3x3 box while scanout holds the port
    base = we_count;
    scan_req = 1;
    for (int i = 0; i < 12; i++) begin
      scan_addr = 15'($urandom_range(NPIX - 1));
      if (i < 9) begin
        plot = 1; x = 8'(3 + i % 3); y = 7'(9 + i / 3); colour = 3'($urandom);
      end else begin
        plot = 0;
      end
      tick();
      if (i == 8) begin
        check("t2_overflow", int'(overflow), 1);
        check("t2_ready", int'(ready), 0);
      end
    end
    scan_req = 0;
    plot = 0;
    wait_idle("t2", 20);
    tick();
    check("t2_writes", we_count - base, 4);

    // 3: out-of-range pixels
    base = we_count;
    plot = 1; x = 8'd160; y = 7'd0;
    tick();
    x = 8'd0; y = 7'd120;
    tick();
    plot = 0;
    check("t3_oob", int'(oob_count), 2);
    tick();
    tick();
    check("t3_writes", we_count - base, 0);

    // Random plots and scanout reads
    for (int i = 0; i < 1500; i++) begin
      plot = ($urandom_range(99) < 60);
      if ($urandom_range(9) == 0) begin
        x = 8'($urandom_range(255)); y = 7'($urandom_range(127));
      end else begin
        x = 8'($urandom_range(W - 1)); y = 7'($urandom_range(H - 1));
      end
      colour    = 3'($urandom);
      scan_req  = ($urandom_range(99) < 30);
      scan_addr = 15'($urandom_range(NPIX - 1));
      tick();
    end
    plot = 0;
    scan_req = 0;
    wait_idle("rand", 50);

    // oob_count saturation
    plot = 1; x = 8'd200; y = 7'd5;
    for (int i = 0; i < 260; i++) tick();
    plot = 0;
    check("oob_saturate", int'(oob_count), 255);

    // 4: full clear with scanout stealing every other cycle
    base = we_count;
    clear = 1;
    tick();
    clear = 0;
    n = 0;
    while ((clr_active || pix_q.size() != 0) && n < 45000) begin
      scan_req  = ~scan_req;
      scan_addr = 15'($urandom_range(NPIX - 1));
      tick();
      n++;
    end
    scan_req = 0;
    check("t4_timeout", int'(clr_active), 0);
    tick();
    check("t4_writes", we_count - base, NPIX);
    check("t4_busy_low", int'(busy), 0);

    // 5: clear restarted at address 500 with a pixel queued behind it
    clear = 1;
    tick();
    clear = 0;
    n = 0;
    while (clr_next != 500 && n < 1000) begin
      tick();
      n++;
    end
    check("t5_at_500", int'(mem_addr), 500);
    clear = 1; plot = 1; x = 8'd1; y = 7'd1; colour = 3'b101;
    tick();
    clear = 0;
    plot = 0;
    check("t5_restart_addr", int'(mem_addr), 0);
    check("t5_restart_we", int'(mem_we), 1);
    wait_idle("t5", 21000);
    check("t5_pix_addr", last_pix_addr, 161);
    check("t5_pix_after_last", prev_of_last_pix, NPIX - 1);

    // A few scanout reads over the freshly cleared frame
    for (int i = 0; i < 40; i++) begin
      scan_req  = 1;
      scan_addr = (i == 0) ? 15'd161 : 15'($urandom_range(NPIX - 1));
      tick();
    end
    scan_req = 0;
    tick();

    // 6: reset mid-clear with two pixels pending
    clear = 1;
    tick();
    clear = 0;
    for (int i = 0; i < 100; i++) tick();
    plot = 1; x = 8'd7; y = 7'd2; colour = 3'b001;
    tick();
    x = 8'd8;
    tick();
    plot = 0;
    resetn = 0;
    tick();
    resetn = 1;
    check("t6_we", int'(mem_we), 0);
    check("t6_busy", int'(busy), 0);
    check("t6_ready", int'(ready), 1);
    check("t6_overflow", int'(overflow), 0);
    check("t6_oob", int'(oob_count), 0);
    base = we_count;
    for (int i = 0; i < 20; i++) tick();
    check("t6_writes", we_count - base, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog expired");
  end

endmodule
